dual_btn_debounce: RTL and testbench

Two-channel push-button conditioner feeding the a/b inputs of the two-input Moore/Mealy control FSM. Each channel synchronises a raw, bouncing button into the clock domain, then debounces it with a four-state FSM and down-counter. Each channel produces a clean level and a single-cycle rising-edge tick. The two channels are identical and fully independent.

---
 rtl/dual_btn_debounce.sv | 124 ++++++++++++
 tb/tb_dual_btn_debounce.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dual_btn_debounce.sv
// Two independent push-button conditioners: 2-flop synchroniser, four-state
// debounce FSM with a reload/down-counter, clean level and rising-edge tick.

module dual_btn_debounce_ch #(
  parameter int unsigned DB_CYCLES = 2_000_000,
  parameter int unsigned CNT_W     = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             tick_nxt;

  // State, counter, synchroniser and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ZERO;
      cnt   <= '0;
      level <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      tick  <= tick_nxt;
    end
  end

  // Next state: any disagreeing sample inside a WAIT state falls back to the stable state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ZERO: begin
        if (sync2) begin
          state_nxt = WAIT1;
          cnt_nxt   = RELOAD;
        end
      end
      WAIT1: begin
        if (!sync2)           state_nxt = ZERO;
        else if (cnt == '0)   state_nxt = ONE;
        else                  cnt_nxt   = cnt - CNT_ONE;
      end
      ONE: begin
        if (!sync2) begin
          state_nxt = WAIT0;
          cnt_nxt   = RELOAD;
        end
      end
      WAIT0: begin
        if (sync2)            state_nxt = ONE;
        else if (cnt == '0)   state_nxt = ZERO;
        else                  cnt_nxt   = cnt - CNT_ONE;
      end
      default: state_nxt = ZERO;
    endcase
  end

  // Output decode from the next state so the registered level tracks the state register
  always_comb begin
    level_nxt = 1'b0;
    tick_nxt  = 1'b0;
    if (state_nxt == ONE || state_nxt == WAIT0) level_nxt = 1'b1;
    if (state == WAIT1 && state_nxt == ONE)     tick_nxt  = 1'b1;
  end

endmodule

module dual_btn_debounce #(
  parameter int unsigned DB_CYCLES = 2_000_000,
  parameter int unsigned CNT_W     = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_tick,
  output logic b_tick
);

  dual_btn_debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_a (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_a_raw),
    .level   (a),
    .tick    (a_tick)
  );

  dual_btn_debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_b (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_b_raw),
    .level   (b),
    .tick    (b_tick)
  );

endmodule

// File: tb/tb_dual_btn_debounce.sv
// Directed bench for dual_btn_debounce with N=4; outputs checked as {a,a_tick,b,b_tick}.

module tb_dual_btn_debounce;

  logic clk;
  logic reset;
  logic btn_a_raw;
  logic btn_b_raw;
  logic a;
  logic b;
  logic a_tick;
  logic b_tick;

  int checks;
  int passed;

  dual_btn_debounce #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_a_raw (btn_a_raw),
    .btn_b_raw (btn_b_raw),
    .a         (a),
    .b         (b),
    .a_tick    (a_tick),
    .b_tick    (b_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {a, a_tick, b, b_tick};
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: {a,a_tick,b,b_tick} observed=%b expected=%b", tag, obs, exp);
  endtask

  // Advance n edges, checking outputs 1 time unit after each edge
  task automatic run(input int n, input logic [3:0] exp, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(tag, exp);
    end
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    reset     = 1'b1;
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    run(2, 4'b0000, "reset_state");
    reset = 1'b0;
    run(2, 4'b0000, "idle");

    // Accept: 5 high samples, level rises after edge t0+6, falls 6 edges after first low
    btn_a_raw = 1'b1;
    run(5, 4'b0000, "accept_qualify");
    btn_a_raw = 1'b0;
    run(1, 4'b0000, "accept_qualify_tail");
    run(1, 4'b1100, "accept_rise_tick");
    run(4, 4'b1000, "accept_hold");
    run(1, 4'b0000, "accept_fall");
    run(2, 4'b0000, "accept_idle");

    // Reject: exactly N high samples
    btn_a_raw = 1'b1;
    run(4, 4'b0000, "reject_high");
    btn_a_raw = 1'b0;
    run(10, 4'b0000, "reject_low");

    // Bounce 1,0,1,1,0 then steady high
    btn_a_raw = 1'b1; run(1, 4'b0000, "bounce");
    btn_a_raw = 1'b0; run(1, 4'b0000, "bounce");
    btn_a_raw = 1'b1; run(2, 4'b0000, "bounce");
    btn_a_raw = 1'b0; run(1, 4'b0000, "bounce");
    btn_a_raw = 1'b1;
    run(6, 4'b0000, "bounce_qualify");
    run(1, 4'b1100, "bounce_rise_tick");
    run(1, 4'b1000, "bounce_single_tick");

    // Low glitch of 2 samples while accepted
    btn_a_raw = 1'b0;
    run(2, 4'b1000, "glitch_low");
    btn_a_raw = 1'b1;
    run(8, 4'b1000, "glitch_no_retick");
    btn_a_raw = 1'b0;
    run(6, 4'b1000, "glitch_release_hold");
    run(1, 4'b0000, "glitch_release_fall");

    // Simultaneous A and B
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    run(6, 4'b0000, "simul_qualify");
    run(1, 4'b1111, "simul_rise_tick");
    run(1, 4'b1010, "simul_hold");
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    run(6, 4'b1010, "simul_release");
    run(1, 4'b0000, "simul_fall");

    // B delayed 3 edges behind A
    btn_a_raw = 1'b1;
    run(3, 4'b0000, "lag_a_only");
    btn_b_raw = 1'b1;
    run(3, 4'b0000, "lag_qualify");
    run(1, 4'b1100, "lag_a_tick");
    run(2, 4'b1000, "lag_a_hold");
    run(1, 4'b1011, "lag_b_tick");
    run(1, 4'b1010, "lag_both_hold");
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    run(6, 4'b1010, "lag_release");
    run(1, 4'b0000, "lag_fall");

    // B accepted, A mid-WAIT1, then async reset
    btn_b_raw = 1'b1;
    run(6, 4'b0000, "rst_b_qualify");
    run(1, 4'b0011, "rst_b_tick");
    run(1, 4'b0010, "rst_b_hold");
    btn_b_raw = 1'b0;
    btn_a_raw = 1'b1;
    run(3, 4'b0010, "rst_a_wait1");
    #2 reset = 1'b1;
    #1 check("rst_async_clear", 4'b0000);
    @(posedge clk);
    #1 check("rst_held", 4'b0000);
    reset = 1'b0;
    run(6, 4'b0000, "rst_requalify");
    run(1, 4'b1100, "rst_single_tick");
    run(3, 4'b1000, "rst_hold");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
